// File: rtl/rv_pkg.sv
// Shared fetch-path definitions: the NOP encoding, fetch FSM states and the
// fetch-queue entry layout.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch queue; the head entry is driven straight from storage so
// decode sees it without a register stage.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is reset because the head outputs read it directly
            // and must show zeros after reset; a plain FIFO would skip this.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, queues
// fetched instructions (or a NOP for misaligned PCs) toward decode.
module instr_fetch_unit #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    input  logic        flush,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_misaligned
);

    import rv_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_fetch_unit: DEPTH must be a power of two in 2..8");
    end

    fetch_state_t  state;
    logic [31:0]   pending_pc;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic          aligned;
    logic          can_fetch;
    logic          mis_push;
    logic          rsp_push;
    logic          push;
    logic          pop;

    // A slot is reserved at issue time, so the response push never meets a full queue.
    assign aligned    = (fetch_pc[1:0] == 2'b00);
    assign can_fetch  = !rst && (state == IDLE) && !q_full && !flush;
    assign imem_req   = can_fetch && aligned;
    assign mis_push   = can_fetch && !aligned;
    assign rsp_push   = !rst && (state == WAIT) && imem_rvalid && !flush;
    assign pc_advance = (imem_req && imem_gnt) || mis_push;
    assign push       = mis_push || rsp_push;
    assign pop        = id_ready && !q_empty;
    assign imem_addr  = fetch_pc;

    assign push_entry = mis_push ? '{pc: fetch_pc, instr: NOP_INSTR, misaligned: 1'b1}
                                 : '{pc: pending_pc, instr: imem_rdata, misaligned: 1'b0};

    assign id_valid      = (q_count != '0);
    assign id_instr      = head.instr;
    assign id_pc         = head.pc;
    assign id_misaligned = head.misaligned;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imem_req && imem_gnt) begin
                        pending_pc <= fetch_pc;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid)  state <= IDLE;
                    else if (flush)   state <= DROP;
                end
                DROP: begin
                    if (imem_rvalid)  state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (flush),
        .push_data (push_entry),
        .head_data (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized-order checks for instr_fetch_unit with a simple
// instruction-memory model driven from the bench.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_misaligned;

    int n_checks = 0;
    int n_errors = 0;

    // memory model state for the randomized run
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_data;
    int          n_pop;
    rv_pkg::fetch_entry_t exp_q[$];

    instr_fetch_unit #(.DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_pc      (fetch_pc),
        .flush         (flush),
        .pc_advance    (pc_advance),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_misaligned (id_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0050_0093 + addr;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit with_checks);
        rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0; fetch_pc = '0;
        tick();
        tick();
        if (with_checks) begin
            check("rst_req",    imem_req,      0);
            check("rst_adv",    pc_advance,    0);
            check("rst_valid",  id_valid,      0);
            check("rst_mis",    id_misaligned, 0);
            check("rst_instr",  id_instr,      0);
            check("rst_pc",     id_pc,         0);
        end
        rst = 1'b0;
    endtask

    task automatic rand_cycle();
        logic        adv;
        logic [31:0] cur_pc;
        rv_pkg::fetch_entry_t e;
        id_ready    = ($urandom_range(0, 2) != 0);
        imem_rvalid = 1'b0;
        if (mem_busy) begin
            if (mem_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data;
                mem_busy    = 1'b0;
            end else begin
                mem_wait--;
            end
        end
        imem_gnt = ($urandom_range(0, 3) != 0);
        #1;
        if (imem_req) check("rand_addr", imem_addr, fetch_pc);
        if (imem_req && imem_gnt) begin
            mem_busy = 1'b1;
            mem_wait = $urandom_range(0, 3);
            mem_data = mem_word(fetch_pc);
        end
        adv    = pc_advance;
        cur_pc = fetch_pc;
        if (adv) begin
            e.pc         = cur_pc;
            e.misaligned = (cur_pc[1:0] != 2'b00);
            e.instr      = e.misaligned ? rv_pkg::NOP_INSTR : mem_word(cur_pc);
            exp_q.push_back(e);
        end
        if (id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                check("rand_extra", id_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("rand_pc",    id_pc,         e.pc);
                check("rand_instr", id_instr,      e.instr);
                check("rand_mis",   id_misaligned, e.misaligned);
            end
            n_pop++;
        end
        tick();
        if (adv) fetch_pc = ($urandom_range(0, 15) == 0) ? cur_pc + 32'd2 : cur_pc + 32'd4;
    endtask

    initial begin
        int cycles;

        // Reset state and single fetch at 1-cycle latency
        do_reset(1'b1);
        fetch_pc = 32'h0; id_ready = 1'b1; imem_gnt = 1'b1;
        #1;
        check("t1_req",   imem_req,   1);
        check("t1_adv",   pc_advance, 1);
        check("t1_addr",  imem_addr,  32'h0);
        tick();
        fetch_pc = 32'h4; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        #1;
        check("t1_wait_req", imem_req, 0);
        check("t1_wait_vld", id_valid, 0);
        tick();
        imem_rvalid = 1'b0; imem_gnt = 1'b0;
        #1;
        check("t1_valid", id_valid,      1);
        check("t1_pc",    id_pc,         32'h0);
        check("t1_instr", id_instr,      32'h0050_0093);
        check("t1_mis",   id_misaligned, 0);
        tick();
        check("t1_popped", id_valid, 0);

        // Back-pressure: two fetches fill the queue, then in-order drain
        do_reset(1'b0);
        fetch_pc = 32'h0; imem_gnt = 1'b1;
        #1 check("t2_req0", imem_req, 1);
        tick();
        fetch_pc = 32'h4; imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0;
        #1 check("t2_req1", imem_req, 1);
        tick();
        fetch_pc = 32'h8; imem_rvalid = 1'b1; imem_rdata = mem_word(32'h4);
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_full_req", imem_req,   0);
            check("t2_full_adv", pc_advance, 0);
            tick();
        end
        imem_gnt = 1'b0; id_ready = 1'b1;
        #1;
        check("t2_pc0",    id_pc,    32'h0);
        check("t2_instr0", id_instr, mem_word(32'h0));
        tick();
        check("t2_pc1",    id_pc,    32'h4);
        check("t2_instr1", id_instr, mem_word(32'h4));
        tick();
        check("t2_empty",  id_valid, 0);

        // Flush while waiting; late response is dropped
        do_reset(1'b0);
        fetch_pc = 32'h40; imem_gnt = 1'b1;
        tick();
        flush = 1'b1; fetch_pc = 32'h100;
        #1;
        check("t3_flush_req", imem_req,   0);
        check("t3_flush_adv", pc_advance, 0);
        tick();
        flush = 1'b0;
        #1 check("t3_drop_req", imem_req, 0);
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1 check("t3_drop_req2", imem_req, 0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("t3_no_push", id_valid,  0);
        check("t3_req_new", imem_req,  1);
        check("t3_addr",    imem_addr, 32'h100);
        tick();
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h100); fetch_pc = 32'h200;
        tick();
        imem_rvalid = 1'b0;
        #1;
        check("t3_pc",    id_pc,    32'h100);
        check("t3_instr", id_instr, mem_word(32'h100));
        check("t3_req2",  imem_req, 1);
        tick();
        flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; id_ready = 1'b1;
        #1 check("t3_hs_valid", id_valid, 1);
        tick();
        flush = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b0; fetch_pc = 32'h300;
        #1;
        check("t3_cleared", id_valid, 0);
        check("t3_idle",    imem_req, 1);

        // Misaligned PC produces a flagged NOP
        do_reset(1'b0);
        fetch_pc = 32'h102; imem_gnt = 1'b1;
        #1;
        check("t4_req", imem_req,   0);
        check("t4_adv", pc_advance, 1);
        tick();
        fetch_pc = 32'h104; imem_gnt = 1'b0;
        #1;
        check("t4_adv_once", pc_advance,    0);
        check("t4_valid",    id_valid,      1);
        check("t4_pc",       id_pc,         32'h102);
        check("t4_instr",    id_instr,      32'h0000_0013);
        check("t4_mis",      id_misaligned, 1);

        // Reset mid-transaction; stale response ignored
        do_reset(1'b0);
        fetch_pc = 32'h0; imem_gnt = 1'b1;
        tick();
        rst = 1'b1; imem_gnt = 1'b0;
        tick();
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        #1 check("t5_valid0", id_valid, 0);
        tick();
        check("t5_valid1", id_valid, 0);

        // Random ready and latency 1..4 over 1000 fetches
        do_reset(1'b0);
        mem_busy = 1'b0; mem_wait = 0; n_pop = 0; cycles = 0;
        while (n_pop < 1000 && cycles < 40000) begin
            rand_cycle();
            cycles++;
        end
        check("rand_pops", n_pop, 1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
